// File: rtl/timer_counter_pkg.sv
// Shared types and defaults for the programmable timer/counter.
// Run-control state encoding and the default prescaler width.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PRESCALE_SIZE_DEFAULT = 4;

endpackage

// File: rtl/timer_counter_prescaler.sv
// Clock-enable divider: strobes once every prescale+1 enabled cycles.
// The compare is live, so a prescale change takes effect at the next compare.
module prescaler #(
    parameter int PRESCALE_SIZE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    output logic                     strobe
);

    localparam logic [PRESCALE_SIZE-1:0] ONE = PRESCALE_SIZE'(1);

    logic [PRESCALE_SIZE-1:0] count_r;

    assign strobe = enable && (count_r == prescale);

    // Phase counter; a value above prescale wraps round until it matches again.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (count_r == prescale) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Programmable up/down interval timer with limit, load, one-shot mode,
// prescaler and IDLE/RUN/DONE run control. All outputs are registered.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int SIZE          = 8,
    parameter int PRESCALE_SIZE = PRESCALE_SIZE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     load,
    input  logic [SIZE-1:0]          load_value,
    input  logic [SIZE-1:0]          limit,
    input  logic                     up,
    input  logic                     one_shot,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    output logic [SIZE-1:0]          count,
    output logic                     tick,
    output logic                     running,
    output logic                     done
);

    localparam logic [SIZE-1:0] ZERO = '0;
    localparam logic [SIZE-1:0] ONE  = SIZE'(1);

    state_t          state_r;
    state_t          state_next;
    logic [SIZE-1:0] count_r;
    logic [SIZE-1:0] count_next;
    logic            tick_r;
    logic            tick_next;
    logic            running_r;
    logic            done_r;
    logic            terminal;
    logic            leave_run;
    logic            pre_enable;
    logic            pre_clear;
    logic            strobe;

    assign pre_enable = enable && (state_r == RUN);
    assign pre_clear  = start || stop || load || leave_run;

    prescaler #(
        .PRESCALE_SIZE(PRESCALE_SIZE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (pre_enable),
        .clear   (pre_clear),
        .prescale(prescale),
        .strobe  (strobe)
    );

    // Next state, next count and tick; stop beats start, load beats a strobe.
    always_comb begin
        state_next = state_r;
        count_next = count_r;
        tick_next  = 1'b0;
        terminal   = up ? (count_r == limit) : (count_r == ZERO);
        case (state_r)
            IDLE: begin
                if (load) begin
                    count_next = load_value;
                end else begin
                    count_next = count_r;
                end
                if (start && !stop) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    count_next = load ? load_value : count_r;
                end else if (load) begin
                    count_next = load_value;
                end else if (strobe) begin
                    if (terminal) begin
                        tick_next = 1'b1;
                        if (one_shot) begin
                            state_next = DONE;
                        end else begin
                            count_next = up ? ZERO : limit;
                        end
                    end else begin
                        count_next = up ? (count_r + ONE) : (count_r - ONE);
                    end
                end else begin
                    count_next = count_r;
                end
            end
            DONE: begin
                if (stop || load) begin
                    state_next = IDLE;
                    count_next = load ? load_value : count_r;
                end else if (start) begin
                    state_next = RUN;
                    count_next = up ? ZERO : limit;
                end else begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = count_r;
            end
        endcase
        leave_run = (state_r == RUN) && (state_next != RUN);
    end

    // State, count and status flags, all flopped from their next values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= ZERO;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next;
            count_r   <= count_next;
            tick_r    <= tick_next;
            running_r <= (state_next == RUN);
            done_r    <= (state_next == DONE);
        end
    end

    assign count   = count_r;
    assign tick    = tick_r;
    assign running = running_r;
    assign done    = done_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with constant
// expectations plus randomized traffic checked against a behavioural model.
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic [7:0] limit = 8'd0;
    logic       up = 1'b1;
    logic       one_shot = 1'b0;
    logic [3:0] prescale = 4'd0;
    logic [7:0] count;
    logic       tick;
    logic       running;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = idle, 1 = running, 2 = finished
    int         m_mode = 0;
    logic [7:0] m_count = 8'd0;
    logic       m_tick = 1'b0;
    int         m_phase = 0;

    timer_counter #(.SIZE(8), .PRESCALE_SIZE(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .load(load), .load_value(load_value), .limit(limit), .up(up),
        .one_shot(one_shot), .prescale(prescale), .count(count), .tick(tick),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int  nmode;
        int  ncount;
        bit  fire;
        bit  at_end;
        nmode  = m_mode;
        ncount = m_count;
        m_tick = 1'b0;
        if (reset) begin
            m_mode = 0; m_count = 8'd0; m_phase = 0;
            return;
        end
        fire   = (m_mode == 1) && enable && (m_phase == prescale);
        at_end = up ? (m_count == limit) : (m_count == 0);
        if (m_mode == 0) begin
            if (load) ncount = load_value;
            if (start && !stop) nmode = 1;
        end else if (m_mode == 1) begin
            if (stop) begin
                nmode = 0;
                if (load) ncount = load_value;
            end else if (load) begin
                ncount = load_value;
            end else if (fire && at_end) begin
                m_tick = 1'b1;
                if (one_shot) nmode = 2;
                else ncount = up ? 0 : limit;
            end else if (fire) begin
                ncount = up ? (m_count + 1) % 256 : m_count - 1;
            end
        end else begin
            if (stop || load) begin
                nmode = 0;
                if (load) ncount = load_value;
            end else if (start) begin
                nmode = 1;
                ncount = up ? 0 : limit;
            end
        end
        if (start || stop || load || (m_mode == 1 && nmode != 1)) m_phase = 0;
        else if (m_mode == 1 && enable) m_phase = fire ? 0 : (m_phase + 1) % 16;
        m_mode  = nmode;
        m_count = ncount[7:0];
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0h want 0", count); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0b want 0", tick); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b want 0", running); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    endtask

    task automatic test_up_periodic();
        logic [7:0] ec;
        limit = 8'd3; up = 1'b1; one_shot = 1'b0; prescale = 4'd0; enable = 1'b1;
        start = 1'b1;
        clk_step();
        start = 1'b0;
        n_tests++; if (running !== 1'b1 || count !== 8'd0) begin n_fail++; $display("FAIL up_start got run=%0b cnt=%0h want run=1 cnt=0", running, count); end
        for (int i = 0; i < 8; i++) begin
            clk_step();
            ec = 8'((i + 1) % 4);
            n_tests++; if (count !== ec || tick !== (ec == 8'd0)) begin n_fail++; $display("FAIL up_periodic[%0d] got cnt=%0h tick=%0b want cnt=%0h tick=%0b", i, count, tick, ec, ec == 8'd0); end
        end
    endtask

    task automatic test_down_oneshot();
        int ec;
        stop = 1'b1; clk_step(); stop = 1'b0;
        up = 1'b0; one_shot = 1'b1; limit = 8'd5; prescale = 4'd2; load_value = 8'd5;
        load = 1'b1; start = 1'b1;
        clk_step();
        load = 1'b0; start = 1'b0;
        n_tests++; if (count !== 8'd5 || running !== 1'b1) begin n_fail++; $display("FAIL down_load got cnt=%0h run=%0b want cnt=5 run=1", count, running); end
        for (int k = 1; k <= 18; k++) begin
            clk_step();
            ec = (k / 3 >= 5) ? 0 : 5 - k / 3;
            n_tests++;
            if (count !== 8'(ec) || tick !== (k == 18) || done !== (k == 18) || running !== (k < 18)) begin
                n_fail++;
                $display("FAIL down_oneshot[%0d] got cnt=%0h tick=%0b done=%0b run=%0b want cnt=%0h tick=%0b done=%0b run=%0b",
                         k, count, tick, done, running, ec, k == 18, k == 18, k < 18);
            end
        end
        clk_step();
        n_tests++; if (count !== 8'd0 || tick !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL down_hold got cnt=%0h tick=%0b done=%0b want 0 0 1", count, tick, done); end
        start = 1'b1; clk_step(); start = 1'b0;
        n_tests++; if (count !== 8'd5 || running !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL done_restart got cnt=%0h run=%0b done=%0b want 5 1 0", count, running, done); end
    endtask

    task automatic test_load_wrap();
        logic [7:0] seq [5];
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'h01; seq[3] = 8'h02; seq[4] = 8'h00;
        stop = 1'b1; clk_step(); stop = 1'b0;
        up = 1'b1; limit = 8'd2; prescale = 4'd0; one_shot = 1'b0; load_value = 8'hFE;
        load = 1'b1; start = 1'b1;
        clk_step();
        load = 1'b0; start = 1'b0;
        n_tests++; if (count !== 8'hFE || running !== 1'b1) begin n_fail++; $display("FAIL load_start got cnt=%0h run=%0b want fe 1", count, running); end
        for (int i = 0; i < 5; i++) begin
            clk_step();
            n_tests++; if (count !== seq[i] || tick !== (i == 4)) begin n_fail++; $display("FAIL load_wrap[%0d] got cnt=%0h tick=%0b want cnt=%0h tick=%0b", i, count, tick, seq[i], i == 4); end
        end
    endtask

    task automatic test_start_stop();
        logic [7:0] held;
        enable = 1'b0; stop = 1'b1; clk_step(); stop = 1'b0; enable = 1'b1;
        held = count;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_tests++; if (count !== held || running !== 1'b0) begin n_fail++; $display("FAIL stop_frozen[%0d] got cnt=%0h run=%0b want cnt=%0h run=0", i, count, running, held); end
        end
        start = 1'b1; stop = 1'b1; clk_step(); start = 1'b0; stop = 1'b0;
        n_tests++; if (running !== 1'b0 || count !== held) begin n_fail++; $display("FAIL start_stop_idle got run=%0b cnt=%0h want run=0 cnt=%0h", running, count, held); end
        load_value = 8'd2; load = 1'b1; start = 1'b1; clk_step(); load = 1'b0; start = 1'b0;
        load_value = 8'h77; load = 1'b1; clk_step(); load = 1'b0;
        n_tests++; if (count !== 8'h77 || tick !== 1'b0) begin n_fail++; $display("FAIL load_over_strobe got cnt=%0h tick=%0b want 77 0", count, tick); end
        clk_step();
        n_tests++; if (count !== 8'h78) begin n_fail++; $display("FAIL above_limit_inc got cnt=%0h want 78", count); end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] held;
        prescale = 4'd3; limit = 8'd9; up = 1'b1; one_shot = 1'b0; load_value = 8'd0;
        load = 1'b1; clk_step(); load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            n_tests++; if (count !== m_count || tick !== m_tick) begin n_fail++; $display("FAIL pre_freeze[%0d] got cnt=%0h tick=%0b want cnt=%0h tick=%0b", i, count, tick, m_count, m_tick); end
        end
        held = count;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_step();
            n_tests++; if (count !== held || running !== 1'b1) begin n_fail++; $display("FAIL freeze[%0d] got cnt=%0h run=%0b want cnt=%0h run=1", i, count, running, held); end
        end
        enable = 1'b1;
        clk_step();
        n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL resume1 got cnt=%0h want 1", count); end
        clk_step();
        n_tests++; if (count !== 8'd2) begin n_fail++; $display("FAIL resume2 got cnt=%0h want 2", count); end
    endtask

    task automatic test_reset_mid();
        stop = 1'b1; clk_step(); stop = 1'b0;
        up = 1'b1; one_shot = 1'b1; limit = 8'd1; prescale = 4'd0; load_value = 8'd0;
        load = 1'b1; start = 1'b1; clk_step(); load = 1'b0; start = 1'b0;
        clk_step(); clk_step();
        n_tests++; if (done !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL reach_done got done=%0b tick=%0b want 1 1", done, tick); end
        reset = 1'b1; start = 1'b1; clk_step(); reset = 1'b0; start = 1'b0;
        n_tests++; if (count !== 8'd0 || tick !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_in_done got cnt=%0h tick=%0b run=%0b done=%0b want 0 0 0 0", count, tick, running, done); end
        one_shot = 1'b0; prescale = 4'd5; load_value = 8'h40;
        load = 1'b1; start = 1'b1; clk_step(); load = 1'b0; start = 1'b0;
        clk_step(); clk_step(); clk_step();
        reset = 1'b1; load = 1'b1; clk_step(); reset = 1'b0; load = 1'b0;
        n_tests++; if (count !== 8'd0 || tick !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_in_run got cnt=%0h tick=%0b run=%0b done=%0b want 0 0 0 0", count, tick, running, done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) < 1);
            start      = ($urandom_range(0, 99) < 10);
            stop       = ($urandom_range(0, 99) < 4);
            load       = ($urandom_range(0, 99) < 4);
            enable     = ($urandom_range(0, 99) < 80);
            load_value = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                limit    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
                prescale = 4'($urandom_range(0, 3));
                up       = 1'($urandom);
                one_shot = 1'($urandom);
            end
            clk_step();
            n_tests++; if (count !== m_count) begin n_fail++; $display("FAIL rand_count[%0d] got %0h want %0h", i, count, m_count); end
            n_tests++; if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick[%0d] got %0b want %0b", i, tick, m_tick); end
            n_tests++; if (running !== (m_mode == 1)) begin n_fail++; $display("FAIL rand_running[%0d] got %0b want %0b", i, running, m_mode == 1); end
            n_tests++; if (done !== (m_mode == 2)) begin n_fail++; $display("FAIL rand_done[%0d] got %0b want %0b", i, done, m_mode == 2); end
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_up_periodic();
        test_down_oneshot();
        test_load_wrap();
        test_start_stop();
        test_enable_freeze();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Programmable timer/counter: the parametrised successor of the basic free-running wrap counter. Adds up/down counting, a programmable terminal limit, parallel load, periodic or one-shot mode, a clock prescaler and a start/stop run-control state machine. Drives a registered one-cycle `tick` at every terminal event. Sits beside the processor datapath as a general-purpose interval timer and event counter.

## Interface
- `SIZE`, 8: width of `count`, `limit`, `load_value`.
- `PRESCALE_SIZE`, 4: width of `prescale`; divide ratio is `prescale`+1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `enable`  in  1  global count enable; gates the prescaler.
- `start`  in  1  level, sampled per cycle; run request.
- `stop`  in  1  level, sampled per cycle; halt request.
- `load`  in  1  parallel load strobe.
- `load_value`  in  SIZE  value written to `count` on `load`.
- `limit`  in  SIZE  terminal value: up mode counts 0..limit; down mode counts limit..0.
- `up`  in  1  1 = count up, 0 = count down.
- `one_shot`  in  1  1 = stop in DONE at the terminal event; 0 = periodic.
- `prescale`  in  PRESCALE_SIZE  strobe every `prescale`+1 enabled cycles.
- `count`  out  SIZE  current count, registered.
- `tick`  out  1  registered one-cycle pulse on each terminal event.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. Reset values: `count`=0, `tick`=0, `running`=0, `done`=0, prescaler count=0.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→IDLE on `stop`.
  - RUN→DONE on a one-shot terminal event.
  - DONE→RUN on `start`. `count` is reinitialised to 0 in up mode or `limit` in down mode.
  - DONE→IDLE on `stop` or `load`.
  - `start` in RUN is ignored.
  - `start` and `stop` in the same cycle: `stop` wins.
- Prescaler counts only in RUN while `enable`=1. It emits `strobe` when its count equals `prescale`, then clears to 0. It also clears on `start`, `stop`, `load`, leaving RUN, or reset. With `prescale`=0, `strobe` asserts every enabled RUN cycle.
- On `strobe`, up mode:
  - `count`==`limit`: terminal event. Periodic mode sets `count`←0. One-shot mode holds `count` at `limit` and goes to DONE.
  - Otherwise `count`←`count`+1, modulo 2^SIZE. A count above `limit` wraps through 2^SIZE-1→0 before reaching `limit`.
- On `strobe`, down mode:
  - `count`==0: terminal event. Periodic mode sets `count`←`limit`. One-shot mode holds `count` at 0 and goes to DONE.
  - Otherwise `count`←`count`-1.
- `tick`=1 for exactly the cycle following the edge that performs a terminal event; 0 otherwise.
- `load` is accepted in any state:
  - `count`←`load_value` and the prescaler clears.
  - `load` overrides any `strobe` update in the same cycle; no tick is generated.
  - `load` with `start` in IDLE: `count`←`load_value` and the state becomes RUN.
- `limit`, `up`, `one_shot`, `prescale` are live inputs. Changes take effect at the next strobe or prescaler compare; no other resynchronisation.
- `limit`=0 in periodic mode: a tick on every strobe, with `count` held at 0.

## Timing
- Every output is a flop; no combinational input→output paths.
- `start` sampled at edge N: `running`=1 after edge N. With `prescale`=0 and `enable`=1, the first count update happens at edge N+1.
- Tick period in periodic mode: (`limit`+1)×(`prescale`+1) enabled RUN cycles.
- `enable`=0 freezes the prescaler and `count` without changing state.
- Reset asserted mid-run: all outputs take their reset values at that edge, overriding every other input.

## Structure
- Package `timer_counter_pkg`: state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the `PRESCALE_SIZE` default constant.
- Sub-module `prescaler` (parameter PRESCALE_SIZE). Ports: `clk`, `reset`, `enable`, `clear`, `prescale`, `strobe`.
- Top level holds the FSM, the count datapath and the `tick` register.

## Test plan
- Reset → start, up, periodic, `limit`=3, `prescale`=0, `enable`=1 → `count` 1,2,3,0,1…; `tick` high once per 4 cycles, in the cycle `count` shows 0.
- Down, one-shot, `limit`=5, `prescale`=2 → `count` decrements every 3 cycles to 0; then one `tick`, `done`=1, `running`=0, `count` holds 0. A subsequent `start` → `count`=5, RUN.
- `load_value`=8'hFE with `start`, up, `limit`=2 → `count` FE, FF, 00, 01, 02; tick at the 02→00 terminal only.
- `start` and `stop` together in IDLE → stays IDLE. `stop` in RUN → `count` frozen, `running`=0. `load` with a coincident strobe → `count`=`load_value`, `tick`=0.
- `enable` toggled 0 for 5 cycles mid-run → `count` and prescaler phase frozen, then resume exactly.
- Reset asserted in DONE and again in RUN mid-prescale → `count`=0, `tick`=`running`=`done`=0 on the next cycle.
